// File: rtl/da_fir_filter.sv
// da_fir_filter: N-tap FIR filter computed with bit-serial distributed arithmetic.
// Each accepted sample is processed one input bit-plane per cycle, LSB first.
// For each plane, the coefficients of the taps whose sample bit is set are summed.
// That sum is weighted by the plane position and accumulated.
// The sign plane is subtracted. The full-precision sum is shifted right by H into Y.
// Optional macro DA_FIR_ROUND_EN: round half up before the shift instead of floor.
module da_fir_filter #(
  parameter int N = 16,
  parameter int W = 8,
  parameter int H = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W:0]       Xin,
  input  logic                    coef_we,
  input  logic [$clog2(N)-1:0]    coef_addr,
  input  logic signed [H:0]       coef_data,
  output logic                    out_valid,
  output logic signed [W+N-1:0]   Y
);

  localparam int AW    = $clog2(N);
  localparam int ACC_W = W + H + 2 + AW;
  localparam int PW    = H + 2 + AW;
  localparam int YW    = W + N;
  localparam int FW    = (ACC_W > YW) ? ACC_W : YW;
  localparam int BW    = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Coefficient values loaded by reset. Taps at index 16 and above reset to zero.
  function automatic logic signed [H:0] coef_init(input int idx);
    int v;
    case (idx)
      2:       v = 3;
      4:       v = -15;
      6:       v = 73;
      7:       v = 126;
      8:       v = 80;
      10:      v = -20;
      12:      v = 6;
      14:      v = -1;
      default: v = 0;
    endcase
    return (H+1)'(v);
  endfunction

  state_t                   r_state;
  state_t                   w_state_next;
  logic [BW-1:0]            r_bit;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [W:0]        r_x [N];
  logic signed [H:0]        r_h [N];

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_coef_wr;
  logic                     w_last;
  logic signed [PW-1:0]     w_plane;
  logic signed [ACC_W-1:0]  w_term;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [FW-1:0]     w_round;
  logic signed [FW-1:0]     w_full;

  assign in_ready = w_in_ready;
  assign w_last   = (r_state == CALC) && (r_bit == BW'(W));

  // State register; reset and clear both land in IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next state, handshake and write-enable decode. clear overrides acceptance.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid && !clear) begin
          w_accept     = 1'b1;
          w_state_next = CALC;
        end
      end
      CALC: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_in_ready = 1'b1;
        if (in_valid && !clear) begin
          w_accept     = 1'b1;
          w_state_next = CALC;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (clear) w_state_next = IDLE;
    // Writes land only outside CALC, so an in-flight sample never sees a mixed coefficient set.
    w_coef_wr = coef_we && w_in_ready;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_tap
      // Delay-line slot: newest sample enters slot 0 and the oldest falls off the end.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)      r_x[gi] <= '0;
        else if (clear)    r_x[gi] <= '0;
        else if (w_accept) begin
          if (gi == 0) r_x[gi] <= Xin;
          else         r_x[gi] <= r_x[(gi == 0) ? 0 : gi - 1];
        end
      end

      // Coefficient register: reset table, rewritable by address outside CALC.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                 r_h[gi] <= coef_init(gi);
        else if (w_coef_wr && coef_addr == AW'(gi))   r_h[gi] <= coef_data;
      end
    end
  endgenerate

  // Distributed-arithmetic lookup: sum the coefficients selected by the current bit-plane.
  always_comb begin
    w_plane = '0;
    for (int i = 0; i < N; i++) begin
      if (r_x[i][r_bit]) w_plane = w_plane + PW'(r_h[i]);
    end
  end

  assign w_term     = ACC_W'(w_plane) <<< r_bit;
  assign w_acc_next = (r_bit == BW'(W)) ? (r_acc - w_term) : (r_acc + w_term);

`ifdef DA_FIR_ROUND_EN
  assign w_round = FW'(1) <<< (H - 1);
`else
  assign w_round = '0;
`endif
  assign w_full = FW'(w_acc_next) + w_round;

  // Bit-serial accumulation. The result is published on the edge that ends the last plane.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bit     <= '0;
      r_acc     <= '0;
      Y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clear || w_accept) begin
        r_bit <= '0;
        r_acc <= '0;
      end else if (r_state == CALC) begin
        r_acc <= w_acc_next;
        r_bit <= w_last ? '0 : r_bit + 1'b1;
        if (w_last) begin
          Y         <= YW'(w_full >>> H);
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_da_fir_filter.sv
// Scoreboard bench for da_fir_filter.
// A direct-form convolution model pushes the expected Y on every acceptance.
// A monitor pops and compares on each out_valid strobe.
module tb_da_fir_filter;
  localparam int N = 16;
  localparam int W = 8;
  localparam int H = 8;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  clear = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic signed [W:0]     Xin = '0;
  logic                  coef_we = 1'b0;
  logic [3:0]            coef_addr = '0;
  logic signed [H:0]     coef_data = '0;
  logic                  out_valid;
  logic signed [W+N-1:0] Y;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     out_cnt = 0;
  int     saved;
  int     last_acc = -1;
  bit     stream = 1'b0;
  longint exp_q[$];
  int     acc_q[$];
  longint m_hist[N];
  longint m_coef[N];
  longint mon_e;
  int     mon_a;
  int     rst_tab[16] = '{0, 0, 3, 0, -15, 0, 73, 126, 80, 0, -20, 0, 6, 0, -1, 0};

  da_fir_filter #(.N(N), .W(W), .H(H)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Xin      (Xin),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .Y        (Y)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      m_hist[i] = 0;
      m_coef[i] = (i < 16) ? rst_tab[i] : 0;
    end
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic accept_model(input int x);
    longint s;
    for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = x;
    s = 0;
    for (int i = 0; i < N; i++) s += m_coef[i] * m_hist[i];
`ifdef DA_FIR_ROUND_EN
    s += longint'(1) << (H - 1);
`endif
    exp_q.push_back(s >>> H);
    acc_q.push_back(cyc + 1);
    if (stream && last_acc >= 0) check_val("spacing", cyc + 1 - last_acc, W + 2);
    last_acc = cyc + 1;
  endtask

  // Offer one sample (optionally with a same-edge coefficient write) and wait for acceptance.
  task automatic send(input int x, input bit keep, input bit we, input int addr, input int data);
    int lows;
    lows = 0;
    Xin = (W+1)'(x);
    in_valid = 1'b1;
    coef_we = we;
    coef_addr = 4'(addr);
    coef_data = (H+1)'(data);
    @(negedge clock);
    while (!in_ready && lows < 40) begin
      lows++;
      @(negedge clock);
    end
    if (!in_ready) begin
      check_val("ready_timeout", longint'(in_ready), 1);
    end else begin
      if (stream && last_acc >= 0) check_val("ready_low_in_calc", lows, W + 1);
      if (we) m_coef[addr] = data;
      accept_model(x);
    end
    @(posedge clock);
    #1;
    coef_we = 1'b0;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clock);
      t++;
    end
    if (exp_q.size() != 0) begin
      check_val("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      acc_q.delete();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    for (int i = 0; i < N; i++) m_hist[i] = 0;
  endtask

  task automatic impulse(input int amp);
    send(amp, 1'b0, 1'b0, 0, 0);
    for (int i = 1; i < 16; i++) send(0, 1'b0, 1'b0, 0, 0);
    wait_drain();
  endtask

  // Output monitor: every strobe must match the oldest pending prediction and its latency.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", longint'(out_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = acc_q.pop_front();
        check_val("y", longint'(Y), mon_e);
        // out_valid rises on the (W+1)th edge after the acceptance edge (the DONE cycle).
        check_val("latency", cyc - mon_a, W + 1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_y", longint'(Y), 0);
    check_val("rst_out_valid", longint'(out_valid), 0);
    check_val("rst_in_ready", longint'(in_ready), 1);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Impulse response through the reset coefficient table.
    impulse(255);

    // Step responses with in_valid held high.
    stream = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 20; i++) send(100, 1'b1, 1'b0, 0, 0);
    in_valid = 1'b0;
    stream = 1'b0;
    wait_drain();
    check_val("step_pos", longint'(Y), 98);
    stream = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 20; i++) send(-256, 1'b1, 1'b0, 0, 0);
    in_valid = 1'b0;
    stream = 1'b0;
    wait_drain();
    check_val("step_neg", longint'(Y), -252);

    // clear during the 4th CALC cycle aborts that sample and keeps Y.
    send(255, 1'b0, 1'b0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    void'(exp_q.pop_back());
    void'(acc_q.pop_back());
    saved = out_cnt;
    do_clear();
    repeat (15) @(posedge clock);
    #1;
    check_val("clear_no_out", out_cnt, saved);
    check_val("clear_keeps_y", longint'(Y), -252);
    check_val("clear_idle_ready", longint'(in_ready), 1);
    impulse(255);

    // Coefficient write in IDLE, then impulse: first Y = 127*255 >> 8 = 126.
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_data = 9'sd127;
    @(posedge clock);
    #1;
    coef_we = 1'b0;
    m_coef[0] = 127;
    do_clear();
    send(255, 1'b0, 1'b0, 0, 0);
    wait_drain();
    check_val("coef_wr_idle_y", longint'(Y), 126);

    // Write and sample on the same edge: the sample uses the new h[0] = -100.
    do_clear();
    send(255, 1'b0, 1'b1, 0, -100);
    wait_drain();
    check_val("coef_same_edge_y", longint'(Y), -100);

    // Reset mid-CALC: outputs drop at once, coefficients return to the table.
    send(255, 1'b0, 1'b0, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("midrst_y", longint'(Y), 0);
    check_val("midrst_out_valid", longint'(out_valid), 0);
    reset_model();
    saved = out_cnt;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (15) @(posedge clock);
    #1;
    check_val("midrst_no_out", out_cnt, saved);
    impulse(255);

    // Write during CALC is dropped: h[0] stays 0, so both impulses give Y = 0.
    do_clear();
    send(255, 1'b0, 1'b0, 0, 0);
    @(posedge clock);
    #1;
    coef_we = 1'b1;
    coef_addr = 4'd0;
    coef_data = 9'sd127;
    @(posedge clock);
    #1;
    coef_we = 1'b0;
    wait_drain();
    check_val("coef_wr_calc_y", longint'(Y), 0);
    do_clear();
    send(255, 1'b0, 1'b0, 0, 0);
    wait_drain();
    check_val("coef_wr_calc_dropped", longint'(Y), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
